// File: rtl/adder_seq_ctrl.sv
// Sequential WIDTH*WORDS adder time-sharing one WIDTH-bit ripple slice; result after WORDS cycles, held in DONE until res_ready.
// New operations are accepted only in IDLE. ADDER_SEQ_OVF_EN adds the res_ovf two's-complement overflow output.

module adder_structure #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic [WIDTH:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[WIDTH];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   op_ci,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH*WORDS-1:0] res_sum,
  output logic                   res_co,
`ifdef ADDER_SEQ_OVF_EN
  output logic                   res_ovf,
`endif
  output logic                   busy
);
  localparam int OPW  = WIDTH * WORDS;
  localparam int IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [OPW-1:0]  a_q, b_q;
  logic            carry_q;
  logic [WIDTH-1:0] sl_a, sl_b, sl_sum;
  logic            sl_co;
  logic            accept, last;

  assign sl_a = a_q[idx*WIDTH +: WIDTH];
  assign sl_b = b_q[idx*WIDTH +: WIDTH];
  assign last = (idx == IDX_LAST);

  adder_structure #(.WIDTH(WIDTH)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .ci  (carry_q),
    .sum (sl_sum),
    .co  (sl_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        accept      = start_valid;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_sum <= '0;
      res_co  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      res_ovf <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b;
        carry_q <= op_ci;
        idx     <= '0;
      end
      if (state == RUN) begin
        res_sum[idx*WIDTH +: WIDTH] <= sl_sum;
        carry_q <= sl_co;
        // Wrap on the last slice so idx never points past the operands.
        idx     <= last ? '0 : idx + IDX_ONE;
        if (last) begin
          res_co <= sl_co;
`ifdef ADDER_SEQ_OVF_EN
          // Carry into the MSB recovered as a^b^sum of that bit.
          res_ovf <= sl_a[WIDTH-1] ^ sl_b[WIDTH-1] ^ sl_sum[WIDTH-1] ^ sl_co;
`endif
        end
      end
    end
  end
endmodule
